reg_bank: RTL and testbench



---
 rtl/reg_bank.sv | 83 ++++++++
 tb/tb_reg_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32-entry general-purpose register bank.
// It has one write port and two registered read ports (operands A and B).
// Entry 0 is hard-wired to zero. Entry SP_INDEX resets to SP_RESET.
// Optional macro REG_BANK_BYPASS_EN: when defined, a read that lands on the
// same edge as a write to the same nonzero index returns the value being
// written instead of the old storage contents.
module reg_bank #(
    parameter int          DATA_W   = 32,
    parameter int          SP_INDEX = 29,
    parameter int unsigned SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [4:0]        writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [4:0]        readReg1,
    input  logic [4:0]        readReg2,
    input  logic              abLoad,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam int NUM_REGS = 32;

    // Register file storage. Entry 0 is never written, so it stays at its reset value of 0.
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Values that the output registers capture on the next abLoad edge.
    logic [DATA_W-1:0] rdVal1;
    logic [DATA_W-1:0] rdVal2;

    // A write is effective only when it is enabled and targets a nonzero index.
    logic writeEn;
    assign writeEn = regWrite && (writeReg != 5'd0);

    // Storage update: asynchronous reset loads the reset image; otherwise perform the gated write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_INDEX) begin
                    regs[i] <= DATA_W'(SP_RESET);
                end else begin
                    regs[i] <= '0;
                end
            end
        end else if (writeEn) begin
            regs[writeReg] <= writeData;
        end
    end

    // Read-side selection: index 0 forces zero, and same-edge bypass applies when it is enabled.
    always_comb begin
        rdVal1 = '0;
        rdVal2 = '0;
        if (readReg1 != 5'd0) begin
            rdVal1 = regs[readReg1];
        end
        if (readReg2 != 5'd0) begin
            rdVal2 = regs[readReg2];
        end
`ifdef REG_BANK_BYPASS_EN
        if (writeEn && (readReg1 == writeReg)) begin
            rdVal1 = writeData;
        end
        if (writeEn && (readReg2 == writeReg)) begin
            rdVal2 = writeData;
        end
`endif
    end

    // Operand output registers: clear on reset, load on abLoad, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData1 <= '0;
            readData2 <= '0;
        end else if (abLoad) begin
            readData1 <= rdVal1;
            readData2 <= rdVal2;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed test of reg_bank.
// Each load edge pushes its expected operand pair into exp_q, and a monitor
// pops and compares after every edge on which abLoad was sampled high.
module tb_reg_bank;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          regWrite = 1'b0;
    logic [4:0]    writeReg = '0;
    logic [W-1:0]  writeData = '0;
    logic [4:0]    readReg1 = '0;
    logic [4:0]    readReg2 = '0;
    logic          abLoad = 1'b0;
    logic [W-1:0]  readData1;
    logic [W-1:0]  readData2;

    int nCompared = 0;
    int nMismatched = 0;

    logic [2*W-1:0] exp_q[$];
    string          name_q[$];
    logic           loadSeen = 1'b0;

    reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .abLoad    (abLoad),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    // Clock and reset: a 10-time-unit period. Reset is pulsed directly by the stimulus.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: act=0x%08h req=0x%08h", name, act, req);
        end
    endtask

    // Record whether the last rising edge loaded the output registers.
    always @(posedge clk) loadSeen <= abLoad;

    // Monitor: after each load edge, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (loadSeen) begin
            if (exp_q.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_load: act=load req=no_load");
            end else begin
                logic [2*W-1:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checkVal({nm, "_rd1"}, readData1, e[2*W-1:W]);
                checkVal({nm, "_rd2"}, readData2, e[W-1:0]);
            end
        end
    end

    // Driver: one clock edge with the given controls. If ld is set, it queues the expected outputs.
    task automatic drive(input logic we, input logic [4:0] wr, input logic [W-1:0] wd,
                         input logic ld, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [W-1:0] e1, input logic [W-1:0] e2, input string name);
        @(negedge clk);
        regWrite  = we;
        writeReg  = wr;
        writeData = wd;
        abLoad    = ld;
        readReg1  = r1;
        readReg2  = r2;
        if (ld) begin
            exp_q.push_back({e1, e2});
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        abLoad   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [W-1:0] data);
        drive(1'b1, idx, data, 1'b0, 5'd0, 5'd0, '0, '0, "write");
    endtask

    task automatic ld(input logic [4:0] r1, input logic [4:0] r2,
                      input logic [W-1:0] e1, input logic [W-1:0] e2, input string name);
        drive(1'b0, 5'd0, '0, 1'b1, r1, r2, e1, e2, name);
    endtask

    logic [W-1:0] sameEdgeExp;

    initial begin
`ifdef REG_BANK_BYPASS_EN
        sameEdgeExp = 32'h22;
`else
        sameEdgeExp = 32'h11;
`endif
        // Reset asserted before any clock edge: the outputs must clear immediately.
        #2 reset = 1'b1;
        #1;
        checkVal("reset_rd1", readData1, '0);
        checkVal("reset_rd2", readData2, '0);
        #1 reset = 1'b0;

        ld(5'd29, 5'd5, 32'd227, 32'd0, "reset_sp");

        wr(5'd7, 32'hDEADBEEF);
        ld(5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, "basic");

        wr(5'd0, 32'h12345678);
        ld(5'd0, 5'd7, 32'h0, 32'hDEADBEEF, "zero_p1");
        ld(5'd7, 5'd0, 32'hDEADBEEF, 32'h0, "zero_p2");

        // Same-edge write and read of register 3.
        wr(5'd3, 32'h11);
        drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd3, sameEdgeExp, sameEdgeExp, "same_edge");
        ld(5'd3, 5'd3, 32'h22, 32'h22, "after_same");

        // A stack-pointer write behaves like any other write.
        wr(5'd29, 32'hCAFE0001);
        ld(5'd29, 5'd1, 32'hCAFE0001, 32'h0, "sp_write");

        // Hold: with abLoad low, a write to register 4 must not change the outputs.
        ld(5'd7, 5'd3, 32'hDEADBEEF, 32'h22, "pre_hold");
        drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd4, 5'd4, '0, '0, "hold");
        #1;
        checkVal("hold_rd1", readData1, 32'hDEADBEEF);
        checkVal("hold_rd2", readData2, 32'h22);
        ld(5'd4, 5'd4, 32'h55, 32'h55, "hold_wrote");

        // Reset between edges, partway through the operation.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkVal("midreset_rd1", readData1, '0);
        checkVal("midreset_rd2", readData2, '0);
        #1 reset = 1'b0;
        ld(5'd4, 5'd29, 32'h0, 32'd227, "post_reset_a");
        ld(5'd7, 5'd3, 32'h0, 32'h0, "post_reset_b");

        // Drain: every queued expectation must have been checked.
        repeat (3) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (exp_q.size() != 0) begin
            nMismatched++;
            $display("FAIL drain: act=%0d pending req=0 pending", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
